// File: rtl/rf_writeback_arbiter_if.sv
// rtl/rf_writeback_arbiter_if.sv - result sources and write-back buses of rf_writeback_arbiter
interface rf_writeback_arbiter_if #(
    parameter int ROBINDEX = 6,
    parameter int PREG_W   = 6
);
    logic                FREEZE;

    logic                ALU_valid_IN;
    logic                ALU_regwrite_IN;
    logic [PREG_W-1:0]   ALU_dest_IN;
    logic [31:0]         ALU_data_IN;
    logic [ROBINDEX-1:0] ALU_rob_IN;
    logic                ALU_ready_OUT;

    logic                MEM_valid_IN;
    logic                MEM_regwrite_IN;
    logic [PREG_W-1:0]   MEM_dest_IN;
    logic [31:0]         MEM_data_IN;
    logic [ROBINDEX-1:0] MEM_rob_IN;
    logic                MEM_ready_OUT;

    logic                write_register_flag;
    logic [PREG_W-1:0]   write_register_index;
    logic [31:0]         write_register_data;
    logic                complete_valid_OUT;
    logic [ROBINDEX-1:0] complete_rob_OUT;
    logic                wakeup_valid_OUT;
    logic [PREG_W-1:0]   wakeup_preg_OUT;

    // Pipeline side: drives results and stall, observes readiness and retirement.
    modport master (
        output FREEZE,
        output ALU_valid_IN, ALU_regwrite_IN, ALU_dest_IN, ALU_data_IN, ALU_rob_IN,
        output MEM_valid_IN, MEM_regwrite_IN, MEM_dest_IN, MEM_data_IN, MEM_rob_IN,
        input  ALU_ready_OUT, MEM_ready_OUT,
        input  write_register_flag, write_register_index, write_register_data,
        input  complete_valid_OUT, complete_rob_OUT,
        input  wakeup_valid_OUT, wakeup_preg_OUT
    );

    // Arbiter side.
    modport slave (
        input  FREEZE,
        input  ALU_valid_IN, ALU_regwrite_IN, ALU_dest_IN, ALU_data_IN, ALU_rob_IN,
        input  MEM_valid_IN, MEM_regwrite_IN, MEM_dest_IN, MEM_data_IN, MEM_rob_IN,
        output ALU_ready_OUT, MEM_ready_OUT,
        output write_register_flag, write_register_index, write_register_data,
        output complete_valid_OUT, complete_rob_OUT,
        output wakeup_valid_OUT, wakeup_preg_OUT
    );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// rtl/rf_writeback_arbiter.sv - buffers ALU/MEM results and retires one per cycle round-robin
module rf_writeback_arbiter #(
    parameter int ROBINDEX = 6,
    parameter int PREG_W   = 6,
    parameter int DEPTH    = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    rf_writeback_arbiter_if.slave wb
);
    // DEPTH is a power of two, so pointers wrap naturally at AW bits.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 1 + PREG_W + 32 + ROBINDEX;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [0:0] SRC_ALU = 1'b0;
    localparam logic [0:0] SRC_MEM = 1'b1;

    // Per-source views; bit/element 0 is ALU, 1 is MEM.
    logic [1:0]         push_valid;
    logic [1:0][EW-1:0] push_entry;
    logic [1:0]         ready;
    logic [1:0]         non_empty;
    logic [1:0][EW-1:0] head;
    logic [1:0]         pop;

    logic               grant_valid;
    logic [0:0]         grant_src;
    logic [0:0]         last_grant_q;
    logic [0:0]         last_grant_d;

    logic [EW-1:0]       head_entry;
    logic                head_rw;
    logic [PREG_W-1:0]   head_dest;
    logic [31:0]         head_data;
    logic [ROBINDEX-1:0] head_rob;

    logic                complete_valid_q;
    logic                retire_rw_q;
    logic [PREG_W-1:0]   retire_dest_q;
    logic [31:0]         retire_data_q;
    logic [ROBINDEX-1:0] retire_rob_q;

    // Pack each source's result into one entry word {regwrite, dest, data, rob}.
    always_comb begin
        push_valid = {wb.MEM_valid_IN, wb.ALU_valid_IN};
        push_entry = {{wb.MEM_regwrite_IN, wb.MEM_dest_IN, wb.MEM_data_IN, wb.MEM_rob_IN},
                      {wb.ALU_regwrite_IN, wb.ALU_dest_IN, wb.ALU_data_IN, wb.ALU_rob_IN}};
    end

    assign wb.ALU_ready_OUT = ready[SRC_ALU];
    assign wb.MEM_ready_OUT = ready[SRC_MEM];

    for (genvar s = 0; s < 2; s++) begin : g_src
        logic [EW-1:0] fifo_q [DEPTH];
        logic [AW-1:0] wr_ptr_q;
        logic [AW-1:0] wr_ptr_d;
        logic [AW-1:0] rd_ptr_q;
        logic [AW-1:0] rd_ptr_d;
        logic [CW-1:0] count_q;
        logic [CW-1:0] count_d;
        logic          push;

        // Acceptance looks only at the registered count, so a full FIFO
        // refuses a push even on the edge where it also pops.
        assign ready[s]     = (count_q < FULL_COUNT) && !wb.FREEZE;
        assign non_empty[s] = (count_q != '0);
        assign push         = push_valid[s] && ready[s];
        assign head[s]      = fifo_q[rd_ptr_q];

        // Pointer and occupancy update; push and pop together leave the count alone.
        always_comb begin
            wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_d = pop[s] ? rd_ptr_q + AW'(1) : rd_ptr_q;
            count_d  = count_q;
            if (push && !pop[s]) begin
                count_d = count_q + CW'(1);
            end else if (!push && pop[s]) begin
                count_d = count_q - CW'(1);
            end
        end

        // Reset empties the FIFO; anything buffered is discarded.
        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        // Entry storage; unreset because occupancy gates every read.
        always_ff @(posedge CLK) begin
            if (push) begin
                fifo_q[wr_ptr_q] <= push_entry[s];
            end
        end
    end

    // Round-robin pick between non-empty heads; last_grant tracks the most
    // recent winner, whichever case produced it, and holds when nothing retires.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = last_grant_q;
        if (!wb.FREEZE) begin
            if (non_empty[SRC_ALU] && non_empty[SRC_MEM]) begin
                grant_valid = 1'b1;
                grant_src   = ~last_grant_q;
            end else if (non_empty[SRC_ALU]) begin
                grant_valid = 1'b1;
                grant_src   = SRC_ALU;
            end else if (non_empty[SRC_MEM]) begin
                grant_valid = 1'b1;
                grant_src   = SRC_MEM;
            end
        end
        last_grant_d  = grant_valid ? grant_src : last_grant_q;
        pop[SRC_ALU]  = grant_valid && (grant_src == SRC_ALU);
        pop[SRC_MEM]  = grant_valid && (grant_src == SRC_MEM);
    end

    // Select and unpack the winning head entry.
    always_comb begin
        head_entry = head[grant_src];
        {head_rw, head_dest, head_data, head_rob} = head_entry;
    end

    // Arbitration history; after reset MEM counts as last served so ALU wins a tie.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last_grant_q <= SRC_MEM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // Retirement register: strobes pulse on the popping edge, payload fields hold otherwise.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            complete_valid_q <= 1'b0;
            retire_rw_q      <= 1'b0;
            retire_dest_q    <= '0;
            retire_data_q    <= '0;
            retire_rob_q     <= '0;
        end else if (grant_valid) begin
            complete_valid_q <= 1'b1;
            retire_rw_q      <= head_rw;
            retire_dest_q    <= head_dest;
            retire_data_q    <= head_data;
            retire_rob_q     <= head_rob;
        end else begin
            complete_valid_q <= 1'b0;
            retire_rw_q      <= 1'b0;
        end
    end

    // RF write and wakeup share the retired dest and regwrite.
    assign wb.write_register_flag  = retire_rw_q;
    assign wb.write_register_index = retire_dest_q;
    assign wb.write_register_data  = retire_data_q;
    assign wb.complete_valid_OUT   = complete_valid_q;
    assign wb.complete_rob_OUT     = retire_rob_q;
    assign wb.wakeup_valid_OUT     = retire_rw_q;
    assign wb.wakeup_preg_OUT      = retire_dest_q;
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb/tb_rf_writeback_arbiter.sv - vectors, corner sequences and randomized model check for rf_writeback_arbiter
module tb_rf_writeback_arbiter;
    localparam int ROBINDEX = 6;
    localparam int PREG_W   = 6;
    localparam int DEPTH    = 4;
    localparam int NV       = 20;

    typedef struct packed {
        logic        rw;
        logic [5:0]  dest;
        logic [31:0] data;
        logic [5:0]  rob;
    } ent_t;

    typedef struct packed {
        logic        cv;
        logic        wf;
        logic        wv;
        logic [5:0]  idx;
        logic [31:0] data;
        logic [5:0]  rob;
        logic [5:0]  preg;
    } obs_t;

    typedef struct {
        bit         rst;
        bit         av;
        ent_t       ae;
        bit         mv;
        ent_t       me;
        logic [1:0] e_rdy;
        obs_t       eo;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET = 1'b0;

    rf_writeback_arbiter_if #(.ROBINDEX(ROBINDEX), .PREG_W(PREG_W)) bus ();

    rf_writeback_arbiter #(.ROBINDEX(ROBINDEX), .PREG_W(PREG_W), .DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .wb    (bus.slave)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    ent_t qa[$];
    ent_t qm[$];
    bit   last_mem;
    obs_t mexp;
    ent_t none;
    vec_t v[NV];

    function automatic ent_t e(bit rw, int dest, logic [31:0] data, int rob);
        ent_t r;
        r.rw = rw; r.dest = dest[5:0]; r.data = data; r.rob = rob[5:0];
        return r;
    endfunction

    function automatic obs_t o(bit cv, bit rw, int idx, logic [31:0] data, int rob);
        obs_t r;
        r.cv = cv; r.wf = rw; r.wv = rw; r.idx = idx[5:0];
        r.data = data; r.rob = rob[5:0]; r.preg = idx[5:0];
        return r;
    endfunction

    function automatic vec_t mkv(bit rst, bit av, ent_t ae, bit mv, ent_t me, obs_t eo);
        vec_t r;
        r.rst = rst; r.av = av; r.ae = ae; r.mv = mv; r.me = me;
        r.e_rdy = 2'b11; r.eo = eo;
        return r;
    endfunction

    function automatic obs_t sample();
        obs_t r;
        r.cv   = bus.complete_valid_OUT;
        r.wf   = bus.write_register_flag;
        r.wv   = bus.wakeup_valid_OUT;
        r.idx  = bus.write_register_index;
        r.data = bus.write_register_data;
        r.rob  = bus.complete_rob_OUT;
        r.preg = bus.wakeup_preg_OUT;
        return r;
    endfunction

    function automatic logic [1:0] rdy();
        return {bus.ALU_ready_OUT, bus.MEM_ready_OUT};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input bit frz, input bit av, input ent_t ae, input bit mv, input ent_t me);
        bus.FREEZE          = frz;
        bus.ALU_valid_IN    = av;
        bus.ALU_regwrite_IN = ae.rw;
        bus.ALU_dest_IN     = ae.dest;
        bus.ALU_data_IN     = ae.data;
        bus.ALU_rob_IN      = ae.rob;
        bus.MEM_valid_IN    = mv;
        bus.MEM_regwrite_IN = me.rw;
        bus.MEM_dest_IN     = me.dest;
        bus.MEM_data_IN     = me.data;
        bus.MEM_rob_IN      = me.rob;
    endtask

    task automatic model_reset();
        qa.delete();
        qm.delete();
        last_mem = 1'b1;
        mexp = '0;
    endtask

    // One clock of stimulus, with the reference model deciding readiness,
    // which source retires, and what the output register must show.
    task automatic step(input string tag, input bit frz, input bit av, input ent_t ae,
                        input bit mv, input ent_t me, output bit acc_a, output bit acc_m);
        bit   ra;
        bit   rm;
        int   win;
        ent_t popped;
        drive(frz, av, ae, mv, me);
        #1;
        ra = (qa.size() < DEPTH) && !frz;
        rm = (qm.size() < DEPTH) && !frz;
        chk({tag, " ready"}, 64'(rdy()), 64'({ra, rm}));
        win = 0;
        if (!frz) begin
            if (qa.size() > 0 && qm.size() > 0) win = last_mem ? 1 : 2;
            else if (qa.size() > 0) win = 1;
            else if (qm.size() > 0) win = 2;
        end
        mexp.cv = 1'b0; mexp.wf = 1'b0; mexp.wv = 1'b0;
        if (win != 0) begin
            if (win == 1) popped = qa.pop_front();
            else popped = qm.pop_front();
            last_mem = (win == 2);
            mexp = o(1'b1, popped.rw, int'(popped.dest), popped.data, int'(popped.rob));
        end
        acc_a = av && ra;
        acc_m = mv && rm;
        if (acc_a) qa.push_back(ae);
        if (acc_m) qm.push_back(me);
        @(posedge CLK);
        #1;
        chk({tag, " out"}, 64'(sample()), 64'(mexp));
    endtask

    task automatic do_reset(input string tag);
        drive(1'b0, 1'b0, none, 1'b0, none);
        RESET = 1'b0;
        #1;
        chk({tag, " async clear"}, 64'(sample()), 64'(0));
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        model_reset();
    endtask

    task automatic drain(input string tag);
        bit a;
        bit b;
        for (int n = 0; n < 20 && (qa.size() + qm.size()) > 0; n++)
            step(tag, 1'b0, 1'b0, none, 1'b0, none, a, b);
        chk({tag, " drained in bound"}, 64'(qa.size() + qm.size()), 64'(0));
    endtask

    initial begin
        bit   aa;
        bit   am;
        bit   full;
        bit   pva;
        bit   pvm;
        bit   frz;
        ent_t pa;
        ent_t pm;

        none = '0;
        model_reset();
        drive(1'b0, 1'b0, none, 1'b0, none);
        repeat (2) @(posedge CLK);
        #1;

        v[0]  = mkv(1, 0, none, 0, none, o(0, 0, 0, 0, 0));
        v[1]  = mkv(0, 1, e(1, 5, 32'hDEAD_BEEF, 3), 0, none, o(0, 0, 0, 0, 0));
        v[2]  = mkv(0, 0, none, 0, none, o(1, 1, 5, 32'hDEAD_BEEF, 3));
        v[3]  = mkv(0, 0, none, 0, none, o(0, 0, 5, 32'hDEAD_BEEF, 3));
        v[4]  = mkv(1, 0, none, 0, none, o(0, 0, 0, 0, 0));
        v[5]  = mkv(0, 1, e(1, 1, 32'h1111_1111, 10), 1, e(1, 2, 32'h2222_2222, 11), o(0, 0, 0, 0, 0));
        v[6]  = mkv(0, 0, none, 0, none, o(1, 1, 1, 32'h1111_1111, 10));
        v[7]  = mkv(0, 0, none, 0, none, o(1, 1, 2, 32'h2222_2222, 11));
        v[8]  = mkv(0, 0, none, 0, none, o(0, 0, 2, 32'h2222_2222, 11));
        v[9]  = mkv(0, 1, e(1, 3, 32'hA3A3_A3A3, 20), 1, e(1, 4, 32'hB3B3_B3B3, 21), o(0, 0, 2, 32'h2222_2222, 11));
        v[10] = mkv(0, 1, e(1, 6, 32'hA4A4_A4A4, 22), 1, e(1, 7, 32'hB4B4_B4B4, 23), o(1, 1, 3, 32'hA3A3_A3A3, 20));
        v[11] = mkv(0, 1, e(1, 8, 32'hA5A5_A5A5, 24), 1, e(1, 9, 32'hB5B5_B5B5, 25), o(1, 1, 4, 32'hB3B3_B3B3, 21));
        v[12] = mkv(0, 0, none, 0, none, o(1, 1, 6, 32'hA4A4_A4A4, 22));
        v[13] = mkv(0, 0, none, 0, none, o(1, 1, 7, 32'hB4B4_B4B4, 23));
        v[14] = mkv(0, 0, none, 0, none, o(1, 1, 8, 32'hA5A5_A5A5, 24));
        v[15] = mkv(0, 0, none, 0, none, o(1, 1, 9, 32'hB5B5_B5B5, 25));
        v[16] = mkv(0, 0, none, 0, none, o(0, 0, 9, 32'hB5B5_B5B5, 25));
        v[17] = mkv(0, 0, none, 1, e(0, 12, 32'h3333_3333, 9), o(0, 0, 9, 32'hB5B5_B5B5, 25));
        v[18] = mkv(0, 0, none, 0, none, o(1, 0, 12, 32'h3333_3333, 9));
        v[19] = mkv(0, 0, none, 0, none, o(0, 0, 12, 32'h3333_3333, 9));

        for (int i = 0; i < NV; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            if (v[i].rst) begin
                drive(1'b0, 1'b0, none, 1'b0, none);
                RESET = 1'b0;
                #1;
                chk({tag, " reset out"}, 64'(sample()), 64'(v[i].eo));
                chk({tag, " reset ready"}, 64'(rdy()), 64'(v[i].e_rdy));
                @(posedge CLK);
                #1;
                RESET = 1'b1;
            end else begin
                drive(1'b0, v[i].av, v[i].ae, v[i].mv, v[i].me);
                #1;
                chk({tag, " ready"}, 64'(rdy()), 64'(v[i].e_rdy));
                @(posedge CLK);
                #1;
                chk({tag, " out"}, 64'(sample()), 64'(v[i].eo));
            end
        end

        // Fill ALU FIFO under dual traffic, refuse a push while full, freeze, drain with wrap.
        do_reset("t4");
        full = 1'b0;
        for (int k = 0; k < 20 && !full; k++) begin
            step("t4 fill", 1'b0, 1'b1, e(1, k, 32'hF000_0000 + k, k),
                 (qm.size() < DEPTH), e(1, 32 + k, 32'hE000_0000 + k, 32 + k), aa, am);
            if (!bus.ALU_ready_OUT) full = 1'b1;
        end
        chk("t4 alu fills", 64'(full), 64'(1));
        chk("t4 ready low when full", 64'(bus.ALU_ready_OUT), 64'(0));
        step("t4 refuse", 1'b0, 1'b1, e(1, 63, 32'hBAD0_0BAD, 63), 1'b0, none, aa, am);
        for (int k = 0; k < 2; k++)
            step("t4 freeze", 1'b1, 1'b1, e(1, 62, 32'hBAD1_1BAD, 62), 1'b0, none, aa, am);
        drain("t4 drain");
        #1;
        chk("t4 ready after drain", 64'(rdy()), 64'(2'b11));

        // Freeze with both FIFOs holding entries, then resume.
        do_reset("t5");
        for (int k = 0; k < 3; k++)
            step("t5 fill", 1'b0, 1'b1, e(1, 10 + k, 32'hC000_0000 + k, k),
                 1'b1, e(0, 20 + k, 32'hD000_0000 + k, 40 + k), aa, am);
        for (int k = 0; k < 3; k++) begin
            step("t5 freeze", 1'b1, 1'b1, e(1, 50, 32'h5050_5050, 50), 1'b1, none, aa, am);
            chk("t5 no pulse", 64'({bus.complete_valid_OUT, bus.write_register_flag, bus.wakeup_valid_OUT}), 64'(0));
        end
        drain("t5 drain");

        // Reset with entries buffered: immediate clear, nothing retires afterwards.
        do_reset("t6 pre");
        step("t6 fill", 1'b0, 1'b1, e(1, 1, 32'h6000_0001, 1), 1'b1, e(1, 2, 32'h6000_0002, 2), aa, am);
        step("t6 fill", 1'b0, 1'b1, e(1, 3, 32'h6000_0003, 3), 1'b1, e(1, 4, 32'h6000_0004, 4), aa, am);
        do_reset("t6 mid");
        for (int k = 0; k < 4; k++)
            step("t6 idle", 1'b0, 1'b0, none, 1'b0, none, aa, am);
        #1;
        chk("t6 ready after reset", 64'(rdy()), 64'(2'b11));

        // Randomized traffic; producers hold a result until it is accepted.
        do_reset("rnd");
        pva = 1'b0;
        pvm = 1'b0;
        pa = none;
        pm = none;
        for (int c = 0; c < 600; c++) begin
            if (!pva && $urandom_range(0, 3) != 0) begin
                pva = 1'b1;
                pa = e($urandom_range(0, 1), $urandom_range(0, 63), $urandom, $urandom_range(0, 63));
            end
            if (!pvm && $urandom_range(0, 3) != 0) begin
                pvm = 1'b1;
                pm = e($urandom_range(0, 1), $urandom_range(0, 63), $urandom, $urandom_range(0, 63));
            end
            frz = ($urandom_range(0, 7) == 0);
            step("rnd", frz, pva, pa, pvm, pm, aa, am);
            if (aa) pva = 1'b0;
            if (am) pvm = 1'b0;
        end
        drain("rnd drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
